button_debounce: RTL and testbench

- Conditions the four raw push-button inputs on wing W1B (odd bits 1/3/5/7) before the BRAM/UART `dut` logic uses them.
- Per button, the block provides:
  - a two-flop synchroniser,
  - a counter-based debounce state machine,
  - a clean level output,
  - single-cycle press and release strobes.
- The `dut` consumes `btn_press` to step its BRAM address (the step is scaled by the `dut`'s SHIFT parameter), so every physical press yields exactly one strobe.

---
 rtl/button_debounce.sv | 165 ++++++++++++++++
 tb/tb_button_debounce.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// button_debounce: per-channel two-flop synchroniser, counter debounce FSM, clean level and
// single-cycle press/release strobes. Optional macro BTN_AUTOREPEAT_EN adds hold-to-repeat
// press strobes after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
module button_debounce #(
    parameter int NBTN          = 4,
    parameter int DEB_CYCLES    = 32000,
    parameter bit INVERT        = 1'b0,
    parameter int REPEAT_DELAY  = 16000000,
    parameter int REPEAT_PERIOD = 3200000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CHK_PRESS, PRESSED, CHK_REL} state_t;

    if (DEB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("button_debounce: DEB_CYCLES must be >= 2 and repeat timings >= 1");
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
`endif

    logic [NBTN-1:0] r_s1;
    logic [NBTN-1:0] r_s2;

    // bring the asynchronous button levels into the clk domain, applying optional inversion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= btn_raw ^ {NBTN{INVERT}};
            r_s2 <= r_s1;
        end
    end

    for (genvar g = 0; g < NBTN; g++) begin : g_ch
        state_t        r_state;
        state_t        w_state_nx;
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] w_cnt_nx;
        logic          r_level;
        logic          w_level_nx;
        logic          r_press;
        logic          w_press_nx;
        logic          r_release;
        logic          w_release_nx;
        logic          w_in;
`ifdef BTN_AUTOREPEAT_EN
        logic [RW-1:0] r_rcnt;
        logic [RW-1:0] w_rcnt_nx;
        logic          r_first;
        logic          w_first_nx;
`endif

        assign w_in = r_s2[g];

        // next-state, qualification counter and strobe decode; a bounce returns to the stable state
        always_comb begin
            w_state_nx   = r_state;
            w_cnt_nx     = r_cnt;
            w_level_nx   = r_level;
            w_press_nx   = 1'b0;
            w_release_nx = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            w_rcnt_nx    = r_rcnt;
            w_first_nx   = r_first;
`endif
            case (r_state)
                IDLE: begin
`ifdef BTN_AUTOREPEAT_EN
                    w_rcnt_nx  = '0;
                    w_first_nx = 1'b1;
`endif
                    if (w_in) begin
                        w_state_nx = CHK_PRESS;
                        w_cnt_nx   = '0;
                    end
                end
                CHK_PRESS: begin
                    if (!w_in) begin
                        w_state_nx = IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nx = PRESSED;
                        w_level_nx = 1'b1;
                        w_press_nx = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        w_rcnt_nx  = '0;
                        w_first_nx = 1'b1;
`endif
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!w_in) begin
                        w_state_nx = CHK_REL;
                        w_cnt_nx   = '0;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (r_rcnt == (r_first ? DLY_LAST : PER_LAST)) begin
                        w_press_nx = 1'b1;
                        w_rcnt_nx  = '0;
                        w_first_nx = 1'b0;
                    end else begin
                        w_rcnt_nx = r_rcnt + 1'b1;
                    end
`endif
                end
                CHK_REL: begin
                    if (w_in) begin
                        w_state_nx = PRESSED;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nx   = IDLE;
                        w_level_nx   = 1'b0;
                        w_release_nx = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end

        // register state, counters and outputs; reset drops any in-flight qualification
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= IDLE;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                r_rcnt    <= '0;
                r_first   <= 1'b1;
`endif
            end else begin
                r_state   <= w_state_nx;
                r_cnt     <= w_cnt_nx;
                r_level   <= w_level_nx;
                r_press   <= w_press_nx;
                r_release <= w_release_nx;
`ifdef BTN_AUTOREPEAT_EN
                r_rcnt    <= w_rcnt_nx;
                r_first   <= w_first_nx;
`endif
            end
        end

        assign btn_level[g]   = r_level;
        assign btn_press[g]   = r_press;
        assign btn_release[g] = r_release;
    end
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed table-driven and hand-sequenced checks of button_debounce
module tb_button_debounce;
    logic       clk = 1'b0;
    logic       rst;
    logic       rst1;
    logic [3:0] raw;
    logic [3:0] raw1;
    logic [3:0] lvl, prs, rel;
    logic [3:0] lvl1, prs1, rel1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    button_debounce #(.NBTN(4), .DEB_CYCLES(4), .INVERT(1'b0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
        .clk(clk), .rst(rst), .btn_raw(raw), .btn_level(lvl), .btn_press(prs), .btn_release(rel));

    button_debounce #(.NBTN(4), .DEB_CYCLES(4), .INVERT(1'b1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut_inv (
        .clk(clk), .rst(rst1), .btn_raw(raw1), .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1));

    typedef struct {
        int         n;
        logic       r;
        logic [3:0] raw;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic r, input logic [3:0] rw, input logic [3:0] l,
                       input logic [3:0] p, input logic [3:0] rl);
        vec_t v;
        v.n = n; v.r = r; v.raw = rw; v.lvl = l; v.prs = p; v.rel = rl;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rw);
        @(negedge clk);
        rst = r;
        raw = rw;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic r, input logic [3:0] rw);
        @(negedge clk);
        rst1 = r;
        raw1 = rw;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   cyc;
        int   idx[$];
        int   exp_idx[$];
        int   rel_at;
        logic other;
        rst  = 1'b1;
        raw  = 4'h0;
        rst1 = 1'b1;
        raw1 = 4'hF;
        // reset with all buttons held, then re-qualification after reset
        add(3, 1, 4'hF, 4'h0, 4'h0, 4'h0);
        add(6, 0, 4'hF, 4'h0, 4'h0, 4'h0);
        add(1, 0, 4'hF, 4'hF, 4'hF, 4'h0);
        add(1, 0, 4'hF, 4'hF, 4'h0, 4'h0);
        // release all
        add(6, 0, 4'h0, 4'hF, 4'h0, 4'h0);
        add(1, 0, 4'h0, 4'h0, 4'h0, 4'hF);
        add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        // two-cycle glitch on bit 1
        add(2, 0, 4'h2, 4'h0, 4'h0, 4'h0);
        add(8, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        // clean 20-cycle press on bit 0
        add(6, 0, 4'h1, 4'h0, 4'h0, 4'h0);
        add(1, 0, 4'h1, 4'h1, 4'h1, 4'h0);
        add(13, 0, 4'h1, 4'h1, 4'h0, 4'h0);
        add(6, 0, 4'h0, 4'h1, 4'h0, 4'h0);
        add(1, 0, 4'h0, 4'h0, 4'h0, 4'h1);
        add(4, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        // bounce 1,0,1,0,1 then steady on bit 2
        add(1, 0, 4'h4, 4'h0, 4'h0, 4'h0);
        add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 0, 4'h4, 4'h0, 4'h0, 4'h0);
        add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(6, 0, 4'h4, 4'h0, 4'h0, 4'h0);
        add(1, 0, 4'h4, 4'h4, 4'h4, 4'h0);
        add(3, 0, 4'h4, 4'h4, 4'h0, 4'h0);
        // reset while held: outputs drop, then one fresh press
        add(2, 1, 4'h4, 4'h0, 4'h0, 4'h0);
        add(6, 0, 4'h4, 4'h0, 4'h0, 4'h0);
        add(1, 0, 4'h4, 4'h4, 4'h4, 4'h0);
        add(1, 0, 4'h4, 4'h4, 4'h0, 4'h0);
        add(6, 0, 4'h0, 4'h4, 4'h0, 4'h0);
        add(1, 0, 4'h0, 4'h0, 4'h0, 4'h4);
        add(3, 0, 4'h0, 4'h0, 4'h0, 4'h0);

        cyc = 0;
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                step(tbl[i].r, tbl[i].raw);
                check("level", cyc, 32'(lvl), 32'(tbl[i].lvl));
                check("press", cyc, 32'(prs), 32'(tbl[i].prs));
                check("release", cyc, 32'(rel), 32'(tbl[i].rel));
                cyc++;
            end
        end

        // hold bit 3 for 60 cycles and log press strobe positions
        rel_at = -1;
        other  = 1'b0;
        for (int c = 0; c < 80; c++) begin
            step(1'b0, (c < 60) ? 4'h8 : 4'h0);
            if (prs[3]) idx.push_back(c);
            if (rel[3] && rel_at < 0) rel_at = c;
            if (prs[2:0] != 3'b000 || rel[2:0] != 3'b000 || (prs[3] && rel[3])) other = 1'b1;
        end
`ifdef BTN_AUTOREPEAT_EN
        exp_idx = '{6, 26, 34, 42, 50, 58};
`else
        exp_idx = '{6};
`endif
        check("repeat_count", 0, 32'(idx.size()), 32'(exp_idx.size()));
        for (int i = 0; i < exp_idx.size() && i < idx.size(); i++)
            check("repeat_pos", i, 32'(idx[i]), 32'(exp_idx[i]));
        check("hold_release_pos", 0, 32'(rel_at), 32'd66);
        check("hold_other_bits", 0, 32'(other), 32'd0);

        // inverted instance: idle-high inputs, then 0101 presses bits 1 and 3 together
        for (int c = 0; c < 2; c++) begin
            step1(1'b1, 4'hF);
            check("inv_rst_out", c, 32'({lvl1, prs1, rel1}), 32'd0);
        end
        for (int c = 0; c < 8; c++) begin
            step1(1'b0, 4'hF);
            check("inv_idle_out", c, 32'({lvl1, prs1, rel1}), 32'd0);
        end
        for (int c = 0; c < 6; c++) begin
            step1(1'b0, 4'h5);
            check("inv_wait_press", c, 32'(prs1), 32'd0);
        end
        step1(1'b0, 4'h5);
        check("inv_press", 0, 32'(prs1), 32'hA);
        check("inv_level", 0, 32'(lvl1), 32'hA);
        step1(1'b0, 4'h5);
        check("inv_press_end", 0, 32'(prs1), 32'h0);
        check("inv_level_hold", 0, 32'(lvl1), 32'hA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
